// File: rtl/gate2_pkg.sv
// Shared definitions for the gate2 self-test: FSM states, z bit positions and the
// golden truth table for the four input vectors.
package gate2_pkg;

  localparam int Z_W    = 6;
  localparam int Z_AND  = 0;
  localparam int Z_NAND = 1;
  localparam int Z_OR   = 2;
  localparam int Z_NOR  = 3;
  localparam int Z_XOR  = 4;
  localparam int Z_XNOR = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Vector index is {a,b}; result packed {XNOR,XOR,NOR,OR,NAND,AND}.
  function automatic logic [Z_W-1:0] expected_z(input logic [1:0] vec);
    logic [Z_W-1:0] e;
    case (vec)
      2'd0:    e = 6'b101010;
      2'd1:    e = 6'b010110;
      2'd2:    e = 6'b010110;
      default: e = 6'b100101;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/gate2_ref.sv
// Golden gate2 model: applied vector {a,b} -> six expected gate outputs.
// Purely combinational, zero latency, no flow control.
module gate2_ref
  import gate2_pkg::*;
(
  input  logic [1:0]     idx,
  output logic [Z_W-1:0] exp_z
);

  assign exp_z = expected_z(idx);

endmodule

// File: rtl/gate2_tester.sv
// Self-test sequencer for gate2: walks {a,b} through 00..11, DWELL cycles per vector,
// then reports pass/fail masks 4*DWELL edges after start; start during a run is ignored.
module gate2_tester
  import gate2_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  output logic           a,
  output logic           b,
  input  logic [Z_W-1:0] z,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [3:0]     fail_mask,
  output logic [Z_W-1:0] err_bits
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

  state_t           state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [Z_W-1:0]   exp_z;
  logic [Z_W-1:0]   diff;
  logic [3:0]       mask_next;

  gate2_ref u_ref (
    .idx   (idx),
    .exp_z (exp_z)
  );

  assign diff = z ^ exp_z;

  always_comb begin
    mask_next      = fail_mask;
    mask_next[idx] = |diff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= 2'd0;
      cnt       <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 4'd0;
      err_bits  <= '0;
    end else if (abort) begin
      state     <= ST_IDLE;
      idx       <= 2'd0;
      cnt       <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 4'd0;
      err_bits  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // Results from a finished run stay visible until the next start.
          if (start) begin
            state     <= ST_APPLY;
            idx       <= 2'd0;
            cnt       <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= 4'd0;
            err_bits  <= '0;
          end
        end
        ST_APPLY: begin
          if (cnt == CNT_MAX) begin
            cnt       <= '0;
            err_bits  <= err_bits | diff;
            fail_mask <= mask_next;
            if (idx == 2'd3) begin
              state <= ST_DONE;
              a     <= 1'b0;
              b     <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (mask_next == 4'd0);
            end else begin
              idx    <= idx + 2'd1;
              {a, b} <= idx + 2'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate2_tester.sv
// Randomised fault-injection bench for gate2_tester (DWELL=4 and DWELL=1 instances)
// with a queue-based scoreboard checked by an independent monitor.
module tb_gate2_tester;

  typedef struct {
    int         inst;
    logic [3:0] fm;
    logic [5:0] eb;
    logic       ps;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] start_v = '0;
  logic [1:0] abort_v = '0;
  logic [1:0][5:0] f0_v = '0;
  logic [1:0][5:0] f1_v = '0;
  logic [1:0][5:0] z_v;
  wire  [1:0] a_v, b_v, busy_v, done_v, pass_v;
  wire  [1:0][3:0] fm_v;
  wire  [1:0][5:0] eb_v;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  gate2_tester #(.DWELL(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
    .a(a_v[0]), .b(b_v[0]), .z(z_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .fail_mask(fm_v[0]), .err_bits(eb_v[0])
  );

  gate2_tester #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
    .a(a_v[1]), .b(b_v[1]), .z(z_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .fail_mask(fm_v[1]), .err_bits(eb_v[1])
  );

  // Ideal gate behaviour from plain boolean operators: {XNOR,XOR,NOR,OR,NAND,AND}.
  function automatic logic [5:0] truth(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a | b), a | b, ~(a & b), a & b};
  endfunction

  // Board-side gate2 with stuck-at-0 (f0) and stuck-at-1 (f1) faults.
  always_comb begin
    for (int j = 0; j < 2; j++)
      z_v[j] = (truth(a_v[j], b_v[j]) & ~f0_v[j]) | f1_v[j];
  end

  function automatic int dwell_of(input int j);
    return (j == 0) ? 4 : 1;
  endfunction

  function automatic exp_t model(input int inst, input logic [5:0] f0, input logic [5:0] f1);
    exp_t e;
    e.inst = inst;
    e.fm   = '0;
    e.eb   = '0;
    for (int i = 0; i < 4; i++) begin
      logic [5:0] ideal;
      logic [5:0] seen;
      ideal = truth(i[1], i[0]);
      seen  = (ideal & ~f0) | f1;
      e.eb  = e.eb | (seen ^ ideal);
      e.fm[i] = (seen != ideal);
    end
    e.ps = (e.fm == 4'd0);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string name, input int j);
    check({name, "_busy"}, 32'(busy_v[j]), 0);
    check({name, "_ab"},   32'({a_v[j], b_v[j]}), 0);
    check({name, "_done"}, 32'(done_v[j]), 0);
    check({name, "_pass"}, 32'(pass_v[j]), 0);
    check({name, "_fm"},   32'(fm_v[j]), 0);
    check({name, "_eb"},   32'(eb_v[j]), 0);
  endtask

  // Monitor: vector sequencing while busy, and scoreboard pop on each rising done.
  int blen[2] = '{0, 0};
  logic [1:0] done_q = '0;
  logic [1:0] busy_q = '0;

  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) begin
      exp_t e;
      if (busy_v[j]) begin
        check("ab_sequence", 32'({a_v[j], b_v[j]}), 32'(blen[j] / dwell_of(j)));
        blen[j]++;
      end else if (done_v[j]) begin
        check("ab_zero_in_done", 32'({a_v[j], b_v[j]}), 0);
      end
      if (done_v[j] && !done_q[j]) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("sb_inst",      32'(j), 32'(e.inst));
          check("sb_fail_mask", 32'(fm_v[j]), 32'(e.fm));
          check("sb_err_bits",  32'(eb_v[j]), 32'(e.eb));
          check("sb_pass",      32'(pass_v[j]), 32'(e.ps));
          check("sb_busy_len",  32'(blen[j]), 32'(4 * dwell_of(j)));
        end
        blen[j] = 0;
      end else if (!busy_v[j] && busy_q[j]) begin
        blen[j] = 0;
      end
      done_q[j] = done_v[j];
      busy_q[j] = busy_v[j];
    end
  end

  task automatic run(input int j, input logic [5:0] f0, input logic [5:0] f1, input int extra);
    bit seen;
    @(negedge clk);
    f0_v[j] = f0;
    f1_v[j] = f1;
    sb_q.push_back(model(j, f0, f1));
    start_v[j] = 1'b1;
    @(negedge clk);
    start_v[j] = 1'b0;
    if (extra > 0) begin
      repeat (extra - 1) @(negedge clk);
      start_v[j] = 1'b1;
      @(negedge clk);
      start_v[j] = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 4 * dwell_of(j) + 8 && !seen; k++) begin
      if (done_v[j]) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_timeout: inst %0d never raised done", j);
    end
  endtask

  initial begin
    #2;
    check_idle("reset4", 0);
    check_idle("reset1", 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset4", 0);

    run(0, 6'b000000, 6'b000000, 0);
    run(0, 6'b010000, 6'b000000, 0);
    run(0, 6'b000000, 6'b000001, 5);
    run(0, 6'b000000, 6'b000000, 0);

    for (int r = 0; r < 8; r++) begin
      logic [5:0] f0, f1;
      f0 = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
      f1 = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
      run(r % 2, f0, f1, 0);
    end
    run(1, 6'b000000, 6'b000000, 0);

    // Abort with start in the same cycle, after vector 0 has already failed.
    @(negedge clk);
    f0_v[0] = '0;
    f1_v[0] = 6'b000001;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_abort_fm", 32'(fm_v[0]), 32'h1);
    abort_v[0] = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    start_v[0] = 1'b0;
    check_idle("abort", 0);
    @(negedge clk);
    check("abort_stays_idle", 32'(busy_v[0]), 0);

    // Asynchronous reset mid-run.
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_busy", 32'(busy_v[0]), 1);
    check("pre_rst_fm", 32'(fm_v[0]), 32'h3);
    #1 rst = 1'b1;
    #1 check_idle("async_rst", 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_no_resume", 32'(busy_v[0]), 0);
    check("sb_drained", 32'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
